// File: rtl/pipeline_pkg.sv
// Shared definitions for the two-stage pipeline controller: opcodes, bubble
// instruction, controller states and writeback-select encodings.
package pipeline_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef struct packed {
    logic       writes_rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       is_mem;
    logic [4:0] rd;
    wb_sel_e    wb_sel;
  } instr_info_t;

endpackage

// File: rtl/pipeline_controller_instr_class.sv
// Opcode classifier: register usage, memory access and writeback source of
// one instruction. Unknown opcodes decode to all-zero class bits.
module instr_class
  import pipeline_pkg::*;
(
  input  logic [31:0] instr_i,
  output instr_info_t info_o
);

  logic [6:0] opcode;
  assign opcode = instr_i[6:0];

  // NOTE: every field gets a default before the case so no path infers a latch.
  always_comb begin
    info_o        = '0;
    info_o.rd     = instr_i[11:7];
    info_o.wb_sel = WB_ALU;
    unique case (opcode)
      OP_OP: begin
        info_o.writes_rd = 1'b1;
        info_o.uses_rs1  = 1'b1;
        info_o.uses_rs2  = 1'b1;
      end
      OP_IMM: begin
        info_o.writes_rd = 1'b1;
        info_o.uses_rs1  = 1'b1;
      end
      OP_LOAD: begin
        info_o.writes_rd = 1'b1;
        info_o.uses_rs1  = 1'b1;
        info_o.is_mem    = 1'b1;
        info_o.wb_sel    = WB_MEM;
      end
      OP_STORE: begin
        info_o.uses_rs1 = 1'b1;
        info_o.uses_rs2 = 1'b1;
        info_o.is_mem   = 1'b1;
      end
      OP_BRANCH: begin
        info_o.uses_rs1 = 1'b1;
        info_o.uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        info_o.writes_rd = 1'b1;
      end
      OP_JAL: begin
        info_o.writes_rd = 1'b1;
        info_o.wb_sel    = WB_PC4;
      end
      OP_JALR: begin
        info_o.writes_rd = 1'b1;
        info_o.uses_rs1  = 1'b1;
        info_o.wb_sel    = WB_PC4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_controller.sv
// Two-stage (DE-EX, MEM-WB) pipeline controller: flush on taken branch,
// WB->EX forwarding, data-memory stall with a sticky timeout fault.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = RV_NOP,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_if_i,
  input  logic [31:0] pc_if_i,
  input  logic        br_taken_i,
  input  logic        dmem_ack_i,
  output logic [31:0] instr_ex_o,
  output logic [31:0] pc_ex_o,
  output logic        pc_en_o,
  output logic        dmem_req_o,
  output logic        fwd_a_o,
  output logic        fwd_b_o,
  output logic        reg_wr_wb_o,
  output logic [4:0]  rd_wb_o,
  output logic [1:0]  wb_sel_o,
  output logic        err_o
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  logic [31:0]   ex_instr_q, ex_instr_d;
  logic [31:0]   ex_pc_q, ex_pc_d;
  logic [31:0]   wb_instr_q, wb_instr_d;
  wb_sel_e       wb_sel_q, wb_sel_d;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  instr_info_t ex_info, wb_info;
  logic        advance;
  logic        mem_stall;

  instr_class u_ex_class (
    .instr_i (ex_instr_q),
    .info_o  (ex_info)
  );

  instr_class u_wb_class (
    .instr_i (wb_instr_q),
    .info_o  (wb_info)
  );

  assign mem_stall = wb_info.is_mem && !dmem_ack_i;
  assign advance   = (state_q == RUN) && !mem_stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          cnt_d   = CW'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = TIMEOUT;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TIMEOUT: err_d = 1'b1;
      default: state_d = RUN;
    endcase
  end

  // Stage registers only move on advance; a branch seen while frozen is dropped.
  always_comb begin
    ex_instr_d = ex_instr_q;
    ex_pc_d    = ex_pc_q;
    wb_instr_d = wb_instr_q;
    wb_sel_d   = wb_sel_q;
    if (advance) begin
      wb_instr_d = ex_instr_q;
      wb_sel_d   = ex_info.wb_sel;
      if (br_taken_i) begin
        ex_instr_d = NOP_INSTR;
        ex_pc_d    = 32'h0;
      end else begin
        ex_instr_d = instr_if_i;
        ex_pc_d    = pc_if_i;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset is synchronous, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_instr_q <= NOP_INSTR;
      ex_pc_q    <= 32'h0;
      wb_instr_q <= NOP_INSTR;
      wb_sel_q   <= WB_ALU;
      state_q    <= RUN;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      ex_instr_q <= ex_instr_d;
      ex_pc_q    <= ex_pc_d;
      wb_instr_q <= wb_instr_d;
      wb_sel_q   <= wb_sel_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign instr_ex_o = ex_instr_q;
  assign pc_ex_o    = ex_pc_q;
  assign rd_wb_o    = wb_instr_q[11:7];
  assign wb_sel_o   = wb_sel_q;
  assign err_o      = err_q;

  assign pc_en_o    = advance;
  assign dmem_req_o = wb_info.is_mem && (state_q != TIMEOUT);

  assign fwd_a_o = wb_info.writes_rd && (wb_info.rd != 5'd0) &&
                   (wb_info.rd == ex_instr_q[19:15]) && ex_info.uses_rs1;
  assign fwd_b_o = wb_info.writes_rd && (wb_info.rd != 5'd0) &&
                   (wb_info.rd == ex_instr_q[24:20]) && ex_info.uses_rs2;

  // Gated by advance so a frozen writeback is reported only once.
  assign reg_wr_wb_o = wb_info.writes_rd && (wb_info.rd != 5'd0) && advance;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: vector table for the running
// pipeline, EX-stage scoreboard, and hand sequences for stall/timeout/reset.
module tb_pipeline_controller;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] LW9   = 32'h0001_2483;  // lw   x9, 0(x2)
  localparam logic [31:0] ADD10 = 32'h0004_8533;  // add  x10, x9, x0
  localparam logic [31:0] NEXT  = 32'h0010_0093;  // addi x1, x0, 1

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_if_i, pc_if_i;
  logic        br_taken_i, dmem_ack_i;
  logic [31:0] instr_ex_o, pc_ex_o;
  logic        pc_en_o, dmem_req_o, fwd_a_o, fwd_b_o, reg_wr_wb_o, err_o;
  logic [4:0]  rd_wb_o;
  logic [1:0]  wb_sel_o;

  always #5 clk = ~clk;

  pipeline_controller #(
    .NOP_INSTR (32'h0000_0013),
    .MAX_WAIT  (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_if_i  (instr_if_i),
    .pc_if_i     (pc_if_i),
    .br_taken_i  (br_taken_i),
    .dmem_ack_i  (dmem_ack_i),
    .instr_ex_o  (instr_ex_o),
    .pc_ex_o     (pc_ex_o),
    .pc_en_o     (pc_en_o),
    .dmem_req_o  (dmem_req_o),
    .fwd_a_o     (fwd_a_o),
    .fwd_b_o     (fwd_b_o),
    .reg_wr_wb_o (reg_wr_wb_o),
    .rd_wb_o     (rd_wb_o),
    .wb_sel_o    (wb_sel_o),
    .err_o       (err_o)
  );

  int errors = 0;
  int checks = 0;
  int wr_pulses = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ex_t;

  typedef struct {
    logic [31:0] instr;
    logic        br;
    logic        fa;
    logic        fb;
    logic        wr;
    logic [4:0]  rd;
    logic [1:0]  sel;
  } vec_t;

  ex_t  sb_q[$];
  ex_t  cur_ex;
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left at posedge+1. Expected EX contents are
  // queued when the bench expects the pipeline to advance, and popped after the edge.
  task automatic cycle(input logic [31:0] instr, input logic [31:0] pc,
                       input logic br, input logic ack, input logic exp_adv);
    ex_t e;
    instr_if_i = instr;
    pc_if_i    = pc;
    br_taken_i = br;
    dmem_ack_i = ack;
    if (exp_adv) begin
      e.instr = br ? NOP : instr;
      e.pc    = br ? 32'h0 : pc;
      sb_q.push_back(e);
    end
    @(negedge clk);
    check("pc_en", {31'b0, pc_en_o}, {31'b0, exp_adv});
    if (reg_wr_wb_o) wr_pulses++;
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) cur_ex = sb_q.pop_front();
    check("instr_ex", instr_ex_o, cur_ex.instr);
    check("pc_ex", pc_ex_o, cur_ex.pc);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cur_ex = '{NOP, 32'h0};
    sb_q.delete();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " instr_ex"}, instr_ex_o, NOP);
    check({tag, " pc_ex"}, pc_ex_o, 32'h0);
    check({tag, " rd_wb"}, {27'b0, rd_wb_o}, 32'd0);
    check({tag, " wb_sel"}, {30'b0, wb_sel_o}, 32'd0);
    check({tag, " err"}, {31'b0, err_o}, 32'd0);
    check({tag, " fwd_a"}, {31'b0, fwd_a_o}, 32'd0);
    check({tag, " fwd_b"}, {31'b0, fwd_b_o}, 32'd0);
    check({tag, " reg_wr"}, {31'b0, reg_wr_wb_o}, 32'd0);
    check({tag, " dmem_req"}, {31'b0, dmem_req_o}, 32'd0);
    check({tag, " pc_en"}, {31'b0, pc_en_o}, 32'd1);
  endtask

  initial begin
    // instr, br, fwd_a, fwd_b, reg_wr, rd_wb, wb_sel seen after the edge
    vecs[0]  = '{32'h0050_0093, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  2'd0}; // addi x1,x0,5
    vecs[1]  = '{32'h0010_8133, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1,  2'd0}; // add x2,x1,x1
    vecs[2]  = '{32'h4051_01B3, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2,  2'd0}; // sub x3,x2,x5
    vecs[3]  = '{32'h1234_52B7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  2'd0}; // lui x5
    vecs[4]  = '{32'h0000_00EF, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  2'd0}; // jal x1
    vecs[5]  = '{32'h0010_8393, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1,  2'd2}; // addi x7,x1,1
    vecs[6]  = '{32'h0050_0093, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7,  2'd0}; // flushed
    vecs[7]  = '{32'h0070_0013, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  2'd0}; // addi x0,x0,7
    vecs[8]  = '{32'h0000_0433, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  2'd0}; // add x8,x0,x0
    vecs[9]  = '{32'h0001_00E7, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8,  2'd0}; // jalr x1,0(x2)
    vecs[10] = '{32'h0000_8FFF, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  2'd2}; // unknown opcode
    vecs[11] = '{32'h0000_0013, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 2'd0}; // nop

    instr_if_i = NOP;
    pc_if_i    = 32'h0;
    br_taken_i = 1'b0;
    dmem_ack_i = 1'b0;
    rst_n      = 1'b0;
    cur_ex     = '{NOP, 32'h0};
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].instr, 32'h100 + 32'(4 * i), vecs[i].br, 1'b0, 1'b1);
      check($sformatf("v%0d fwd_a", i), {31'b0, fwd_a_o}, {31'b0, vecs[i].fa});
      check($sformatf("v%0d fwd_b", i), {31'b0, fwd_b_o}, {31'b0, vecs[i].fb});
      check($sformatf("v%0d reg_wr", i), {31'b0, reg_wr_wb_o}, {31'b0, vecs[i].wr});
      check($sformatf("v%0d rd_wb", i), {27'b0, rd_wb_o}, {27'b0, vecs[i].rd});
      check($sformatf("v%0d wb_sel", i), {30'b0, wb_sel_o}, {30'b0, vecs[i].sel});
    end

    // An ack with no outstanding request changes nothing.
    cycle(NOP, 32'h180, 1'b0, 1'b1, 1'b1);
    check("stray ack dmem_req", {31'b0, dmem_req_o}, 32'd0);
    check("stray ack err", {31'b0, err_o}, 32'd0);

    // Load in WB, ack in the third stalled cycle and held until the advance.
    cycle(LW9, 32'h200, 1'b0, 1'b0, 1'b1);
    cycle(ADD10, 32'h204, 1'b0, 1'b0, 1'b1);
    check("load pc_en", {31'b0, pc_en_o}, 32'd0);
    check("load dmem_req", {31'b0, dmem_req_o}, 32'd1);
    check("load wb_sel", {30'b0, wb_sel_o}, 32'd1);
    check("load rd_wb", {27'b0, rd_wb_o}, 32'd9);
    check("load fwd_a", {31'b0, fwd_a_o}, 32'd1);
    check("load reg_wr", {31'b0, reg_wr_wb_o}, 32'd0);
    wr_pulses = 0;
    cycle(NEXT, 32'h208, 1'b0, 1'b0, 1'b0);
    cycle(NEXT, 32'h208, 1'b1, 1'b0, 1'b0);
    cycle(NEXT, 32'h208, 1'b0, 1'b1, 1'b0);
    cycle(NEXT, 32'h208, 1'b0, 1'b1, 1'b1);
    check("load reg_wr pulses", 32'(wr_pulses), 32'd1);
    check("after load rd_wb", {27'b0, rd_wb_o}, 32'd10);
    check("after load wb_sel", {30'b0, wb_sel_o}, 32'd0);
    check("after load dmem_req", {31'b0, dmem_req_o}, 32'd0);

    // Load with no ack: timeout after the counter reaches 15.
    cycle(LW9, 32'h300, 1'b0, 1'b0, 1'b1);
    cycle(NOP, 32'h304, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 15; k++) cycle(NOP, 32'h308, 1'b0, 1'b0, 1'b0);
    check("wait err before limit", {31'b0, err_o}, 32'd0);
    check("wait dmem_req before limit", {31'b0, dmem_req_o}, 32'd1);
    cycle(NOP, 32'h308, 1'b0, 1'b0, 1'b0);
    check("timeout err", {31'b0, err_o}, 32'd1);
    check("timeout dmem_req", {31'b0, dmem_req_o}, 32'd0);
    for (int k = 0; k < 3; k++) cycle(NOP, 32'h30C, 1'b1, 1'b1, 1'b0);
    check("timeout sticky err", {31'b0, err_o}, 32'd1);
    check("timeout reg_wr", {31'b0, reg_wr_wb_o}, 32'd0);
    check("timeout dmem_req held", {31'b0, dmem_req_o}, 32'd0);
    apply_reset();
    check_reset_state("reset in timeout");
    rst_n = 1'b1;

    // Reset while waiting on memory.
    cycle(LW9, 32'h400, 1'b0, 1'b0, 1'b1);
    cycle(NOP, 32'h404, 1'b0, 1'b0, 1'b1);
    cycle(NOP, 32'h408, 1'b0, 1'b0, 1'b0);
    cycle(NOP, 32'h408, 1'b0, 1'b0, 1'b0);
    apply_reset();
    check_reset_state("reset in mem_wait");
    rst_n = 1'b1;
    cycle(32'h0010_8133, 32'h40C, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
